// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_v4 buffering element.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_v4_mem.sv
// Register-array storage for fifo_v4: one write port, one asynchronous read port.
module fifo_v4_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_v4.sv
// Synchronous FIFO with occupancy count, threshold flags, sticky errors and optional fall-through.
module fifo_v4
    import fifo_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AF_THRESH    = DEPTH - 1,
    parameter int unsigned AE_THRESH    = 1,
    parameter int unsigned CNT_W        = cnt_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  clr_err_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CNT_W-1:0]      usage_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  is_empty, is_full, ft_bypass;
    logic                  push_acc, pop_acc, ovf_err, udf_err;
    logic [DATA_WIDTH-1:0] rd_data;
    fifo_status_t          status;

    always_comb begin
        is_empty  = (count_q == '0);
        is_full   = (count_q == CNT_W'(DEPTH));
        // Push and pop on an empty fall-through FIFO pass data straight through.
        ft_bypass = FALL_THROUGH && is_empty && push_i && pop_i;
        push_acc  = push_i && (!is_full || pop_i) && !ft_bypass && !flush_i;
        pop_acc   = pop_i && !is_empty && !flush_i;
        ovf_err   = push_i && is_full && !pop_i && !flush_i;
        udf_err   = pop_i && is_empty && !(FALL_THROUGH && push_i) && !flush_i;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
        if (push_acc) begin
            wptr_d = (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop_acc) begin
            rptr_d = (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        end
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
        // A new error in the same cycle as a clear leaves the flag set.
        ovf_d = clr_err_i ? 1'b0 : ovf_q;
        udf_d = clr_err_i ? 1'b0 : udf_q;
        if (ovf_err) ovf_d = 1'b1;
        if (udf_err) udf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_v4_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PtrW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push_acc),
        .waddr_i (wptr_q),
        .wdata_i (data_i),
        .raddr_i (rptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        status.full         = is_full;
        status.empty        = is_empty && !(FALL_THROUGH && push_i);
        status.almost_full  = 32'(count_q) >= AF_THRESH;
        status.almost_empty = 32'(count_q) <= AE_THRESH;
        status.overflow     = ovf_q;
        status.underflow    = udf_q;
    end

    assign data_o         = (FALL_THROUGH && is_empty) ? data_i : rd_data;
    assign full_o         = status.full;
    assign empty_o        = status.empty;
    assign almost_full_o  = status.almost_full;
    assign almost_empty_o = status.almost_empty;
    assign usage_o        = count_q;
    assign overflow_o     = status.overflow;
    assign underflow_o    = status.underflow;

endmodule

// File: tb/tb_fifo_v4.sv
// Directed, table-driven bench for fifo_v4 (DEPTH=4, 8-bit) plus a fall-through instance.
module tb_fifo_v4;

    logic       clk;
    logic       rst, flush, clr, push, pop;
    logic [7:0] din, dout;
    logic       full, empty, af, ae, ovf, udf;
    logic [2:0] usage;

    logic       b_flush, b_clr, b_push, b_pop;
    logic [7:0] b_din, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0] b_usage;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_v4 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (8),
        .DEPTH        (4),
        .AF_THRESH    (3),
        .AE_THRESH    (1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .clr_err_i      (clr),
        .data_i         (din),
        .push_i         (push),
        .pop_i          (pop),
        .data_o         (dout),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (af),
        .almost_empty_o (ae),
        .usage_o        (usage),
        .overflow_o     (ovf),
        .underflow_o    (udf)
    );

    fifo_v4 #(
        .FALL_THROUGH (1'b1),
        .DATA_WIDTH   (8),
        .DEPTH        (4),
        .AF_THRESH    (3),
        .AE_THRESH    (1)
    ) dut_ft (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (b_flush),
        .clr_err_i      (b_clr),
        .data_i         (b_din),
        .push_i         (b_push),
        .pop_i          (b_pop),
        .data_o         (b_dout),
        .full_o         (b_full),
        .empty_o        (b_empty),
        .almost_full_o  (b_af),
        .almost_empty_o (b_ae),
        .usage_o        (b_usage),
        .overflow_o     (b_ovf),
        .underflow_o    (b_udf)
    );

    // ctl = {rst, flush, clr, push, pop}; flags = {full, empty, af, ae, ovf, udf}.
    // Expected values are what the DUT shows while the row's inputs are applied.
    typedef struct {
        logic [4:0] ctl;
        logic [7:0] din;
        logic [2:0] usage;
        logic [5:0] flags;
        logic       chk_d;
        logic [7:0] dout;
    } vec_t;

    localparam logic [4:0] IDLE  = 5'b00000;
    localparam logic [4:0] POP   = 5'b00001;
    localparam logic [4:0] PUSH  = 5'b00010;
    localparam logic [4:0] PP    = 5'b00011;
    localparam logic [4:0] CLR   = 5'b00100;
    localparam logic [4:0] CLRPO = 5'b00101;
    localparam logic [4:0] FLPU  = 5'b01010;
    localparam logic [4:0] RSTPU = 5'b10010;

    vec_t vq[$];

    function automatic vec_t v(input logic [4:0] ctl, input logic [7:0] d, input logic [2:0] u,
                               input logic [5:0] f, input logic chk, input logic [7:0] q);
        vec_t r;
        r.ctl = ctl; r.din = d; r.usage = u; r.flags = f; r.chk_d = chk; r.dout = q;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 0; clr = 0; push = 0; pop = 0; din = '0;
        b_flush = 0; b_clr = 0; b_push = 0; b_pop = 0; b_din = '0;

        // Fill / drain
        vq.push_back(v(PUSH,  8'h11, 0, 6'b010100, 0, 8'h00));
        vq.push_back(v(PUSH,  8'h22, 1, 6'b000100, 1, 8'h11));
        vq.push_back(v(PUSH,  8'h33, 2, 6'b000000, 1, 8'h11));
        vq.push_back(v(PUSH,  8'h44, 3, 6'b001000, 1, 8'h11));
        vq.push_back(v(IDLE,  8'h00, 4, 6'b101000, 1, 8'h11));
        // Overflow and clear
        vq.push_back(v(PUSH,  8'h55, 4, 6'b101000, 1, 8'h11));
        vq.push_back(v(IDLE,  8'h00, 4, 6'b101010, 1, 8'h11));
        vq.push_back(v(CLR,   8'h00, 4, 6'b101010, 1, 8'h11));
        vq.push_back(v(IDLE,  8'h00, 4, 6'b101000, 1, 8'h11));
        // Push+pop while full, pointer wrap
        vq.push_back(v(PP,    8'h66, 4, 6'b101000, 1, 8'h11));
        vq.push_back(v(POP,   8'h00, 4, 6'b101000, 1, 8'h22));
        vq.push_back(v(POP,   8'h00, 3, 6'b001000, 1, 8'h33));
        vq.push_back(v(POP,   8'h00, 2, 6'b000000, 1, 8'h44));
        vq.push_back(v(IDLE,  8'h00, 1, 6'b000100, 1, 8'h66));
        vq.push_back(v(POP,   8'h00, 1, 6'b000100, 1, 8'h66));
        // Underflow
        vq.push_back(v(POP,   8'h00, 0, 6'b010100, 0, 8'h00));
        vq.push_back(v(IDLE,  8'h00, 0, 6'b010101, 0, 8'h00));
        vq.push_back(v(PUSH,  8'h77, 0, 6'b010101, 0, 8'h00));
        vq.push_back(v(POP,   8'h00, 1, 6'b000101, 1, 8'h77));
        // Clear, then clear racing a new error
        vq.push_back(v(CLR,   8'h00, 0, 6'b010101, 0, 8'h00));
        vq.push_back(v(CLRPO, 8'h00, 0, 6'b010100, 0, 8'h00));
        vq.push_back(v(IDLE,  8'h00, 0, 6'b010101, 0, 8'h00));
        // Flush with pending push
        vq.push_back(v(PUSH,  8'hA1, 0, 6'b010101, 0, 8'h00));
        vq.push_back(v(PUSH,  8'hA2, 1, 6'b000101, 1, 8'hA1));
        vq.push_back(v(FLPU,  8'hB3, 2, 6'b000001, 1, 8'hA1));
        vq.push_back(v(IDLE,  8'h00, 0, 6'b010101, 0, 8'h00));
        vq.push_back(v(PUSH,  8'hC4, 0, 6'b010101, 0, 8'h00));
        vq.push_back(v(IDLE,  8'h00, 1, 6'b000101, 1, 8'hC4));
        // Reset with push and sticky underflow
        vq.push_back(v(RSTPU, 8'hDD, 1, 6'b000101, 1, 8'hC4));
        vq.push_back(v(IDLE,  8'h00, 0, 6'b010100, 0, 8'h00));

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            {rst, flush, clr, push, pop} = vq[i].ctl;
            din = vq[i].din;
            #1;
            check($sformatf("row%0d usage", i), 32'(usage), 32'(vq[i].usage));
            check($sformatf("row%0d full", i),  32'(full),  32'(vq[i].flags[5]));
            check($sformatf("row%0d empty", i), 32'(empty), 32'(vq[i].flags[4]));
            check($sformatf("row%0d af", i),    32'(af),    32'(vq[i].flags[3]));
            check($sformatf("row%0d ae", i),    32'(ae),    32'(vq[i].flags[2]));
            check($sformatf("row%0d ovf", i),   32'(ovf),   32'(vq[i].flags[1]));
            check($sformatf("row%0d udf", i),   32'(udf),   32'(vq[i].flags[0]));
            if (vq[i].chk_d) check($sformatf("row%0d data", i), 32'(dout), 32'(vq[i].dout));
        end

        // Fall-through instance: reset, then bypass with push+pop on empty
        @(negedge clk);
        {rst, flush, clr, push, pop} = IDLE;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b_push = 1'b1; b_pop = 1'b1; b_din = 8'h99;
        #1;
        check("ft bypass data",  32'(b_dout),  32'h99);
        check("ft bypass empty", 32'(b_empty), 32'd0);
        check("ft bypass usage", 32'(b_usage), 32'd0);
        @(negedge clk);
        b_push = 1'b0; b_pop = 1'b0;
        #1;
        check("ft after usage", 32'(b_usage), 32'd0);
        check("ft after empty", 32'(b_empty), 32'd1);
        check("ft after udf",   32'(b_udf),   32'd0);
        // Push alone on empty: visible now and stored
        @(negedge clk);
        b_push = 1'b1; b_din = 8'hAA;
        #1;
        check("ft push data",  32'(b_dout),  32'hAA);
        check("ft push empty", 32'(b_empty), 32'd0);
        @(negedge clk);
        b_push = 1'b0; b_din = 8'h00;
        #1;
        check("ft stored usage", 32'(b_usage), 32'd1);
        check("ft stored data",  32'(b_dout),  32'hAA);
        b_pop = 1'b1;
        @(negedge clk);
        b_pop = 1'b0;
        #1;
        check("ft drained usage", 32'(b_usage), 32'd0);
        check("ft drained udf",   32'(b_udf),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
